// File: rtl/alu_seq.sv
// Multi-cycle ALU for the Mini-SRC datapath: single-cycle logic/shift ops, radix-2 Booth
// multiply and signed restoring divide behind a start/busy/done handshake.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Zlow,
    output logic [WIDTH-1:0] Zhigh,
    output logic             div_zero
);

    localparam int unsigned SH = $clog2(WIDTH);
    localparam int unsigned CW = SH + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_AND = 5'b00010, OP_OR  = 5'b00011,
        OP_SHR  = 5'b00100, OP_SHRA = 5'b00101, OP_SHL = 5'b00110, OP_ROR = 5'b00111,
        OP_ROL  = 5'b01000, OP_MUL  = 5'b01001, OP_DIV = 5'b01010, OP_NEG = 5'b01110,
        OP_NOT  = 5'b01111
    } op_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             bit_q, bit_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] zlow_q, zlow_d;
    logic [WIDTH-1:0] zhigh_q, zhigh_d;
    logic             div_zero_q, div_zero_d;

    logic [SH-1:0]    sh_amt;
    logic [SH:0]      sh_inv;
    logic [WIDTH-1:0] quick_lo;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   m_ext, booth_sum, booth_hi;
    logic [WIDTH-1:0] booth_lo;
    logic [WIDTH:0]   div_shift, div_trial, div_rem;
    logic [WIDTH-1:0] div_quo;

    always_comb begin
        sh_amt   = B[SH-1:0];
        sh_inv   = (SH+1)'(WIDTH) - {1'b0, sh_amt};
        quick_lo = '0;
        case (op)
            OP_ADD:  quick_lo = A + B;
            OP_SUB:  quick_lo = A - B;
            OP_AND:  quick_lo = A & B;
            OP_OR:   quick_lo = A | B;
            OP_SHR:  quick_lo = A >> sh_amt;
            OP_SHRA: quick_lo = $signed(A) >>> sh_amt;
            OP_SHL:  quick_lo = A << sh_amt;
            // a shift by sh_inv == WIDTH yields zero, so s=0 rotates to A itself
            OP_ROR:  quick_lo = (A >> sh_amt) | (A << sh_inv);
            OP_ROL:  quick_lo = (A << sh_amt) | (A >> sh_inv);
            OP_NEG:  quick_lo = -A;
            OP_NOT:  quick_lo = ~A;
            default: quick_lo = '0;
        endcase
        a_abs = A[WIDTH-1] ? -A : A;
        b_abs = B[WIDTH-1] ? -B : B;
    end

    // Booth step on {hi, lo, bit}; hi carries one guard bit so MIN*MIN cannot overflow
    always_comb begin
        m_ext = {opb_q[WIDTH-1], opb_q};
        case ({lo_q[0], bit_q})
            2'b01:   booth_sum = hi_q + m_ext;
            2'b10:   booth_sum = hi_q - m_ext;
            default: booth_sum = hi_q;
        endcase
        booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo = {booth_sum[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        if (!div_trial[WIDTH]) begin
            div_rem = div_trial;
            div_quo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem = div_shift;
            div_quo = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opb_d      = opb_q;
        bit_d      = bit_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        zlow_d     = zlow_q;
        zhigh_d    = zhigh_q;
        div_zero_d = div_zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    div_zero_d = 1'b0;
                    case (op)
                        OP_MUL: begin
                            state_d = S_MUL;
                            cnt_d   = CW'(WIDTH);
                            hi_d    = '0;
                            lo_d    = A;
                            opb_d   = B;
                            bit_d   = 1'b0;
                        end
                        OP_DIV: begin
                            if (B == '0) begin
                                state_d    = S_DONE;
                                zlow_d     = '1;
                                zhigh_d    = A;
                                div_zero_d = 1'b1;
                            end else begin
                                state_d = S_DIV;
                                cnt_d   = CW'(WIDTH);
                                hi_d    = '0;
                                lo_d    = a_abs;
                                opb_d   = b_abs;
                                neg_q_d = A[WIDTH-1] ^ B[WIDTH-1];
                                neg_r_d = A[WIDTH-1];
                            end
                        end
                        default: begin
                            state_d = S_DONE;
                            zlow_d  = quick_lo;
                            zhigh_d = '0;
                        end
                    endcase
                end
            end
            S_MUL: begin
                hi_d  = booth_hi;
                lo_d  = booth_lo;
                bit_d = lo_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    zhigh_d = booth_hi[WIDTH-1:0];
                    zlow_d  = booth_lo;
                end
            end
            S_DIV: begin
                hi_d  = div_rem;
                lo_d  = div_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                zlow_d  = neg_q_q ? -lo_q : lo_q;
                zhigh_d = neg_r_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            bit_q      <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            zlow_q     <= '0;
            zhigh_q    <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            opb_q      <= opb_d;
            bit_q      <= bit_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            zlow_q     <= zlow_d;
            zhigh_q    <= zhigh_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign Zlow     = zlow_q;
    assign Zhigh    = zhigh_q;
    assign div_zero = div_zero_q;

endmodule
